// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the mem_master memory-port initiator
package mem_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/mem_master_stats.sv
// mem_master_stats: wrapping 16-bit read-response and write-issue counters
//   clk, reset (sync, active-low), rd_inc_i/wr_inc_i pulses, rd_count_o/wr_count_o totals
module mem_master_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_inc_i,
  input  logic        wr_inc_i,
  output logic [15:0] rd_count_o,
  output logic [15:0] wr_count_o
);
  logic [15:0] rd_q, wr_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      rd_q <= rd_q + 16'(rd_inc_i);
      wr_q <= wr_q + 16'(wr_inc_i);
    end
  end
  assign rd_count_o = rd_q;
  assign wr_count_o = wr_q;
endmodule

// File: rtl/mem_master.sv
// mem_master: single-outstanding read/write initiator for the mem block memory port
//   clk, reset (sync, active-low)
//   cmd_*  : upstream command channel (valid/ready), rd_wr 1=read 0=write
//   resp_* : read response channel (valid/ready)
//   mem_*  : memory port, one-cycle enable per command, read data sampled READ_LATENCY edges after issue
//   MEM_MASTER_STATS_EN adds rd_count/wr_count outputs
module mem_master
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_W_DEF,
  parameter int ADDR_WIDTH   = ADDR_W_DEF,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wr_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  mem_enable,
  output logic                  mem_rd_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
`ifdef MEM_MASTER_STATS_EN
  ,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
`endif
);
  state_t                state_q;
  logic                  cmd_ready_q, resp_valid_q, mem_enable_q, mem_rd_wr_q;
  logic [DATA_WIDTH-1:0] resp_data_q, mem_wr_data_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [2:0]            cnt_q, cnt_d;
  assign cnt_d = cnt_q - 3'd1;
  // The mem_* registers double as the command latch: they load on accept and hold afterwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      mem_enable_q  <= 1'b0;
      mem_rd_wr_q   <= RD;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q   <= 1'b0;
            mem_enable_q  <= 1'b1;
            mem_rd_wr_q   <= cmd_rd_wr;
            mem_addr_q    <= cmd_addr;
            mem_wr_data_q <= cmd_wr_data;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          mem_enable_q <= 1'b0;
          cnt_q        <= 3'(READ_LATENCY);
          cmd_ready_q  <= mem_rd_wr_q == WR;
          state_q      <= mem_rd_wr_q == RD ? WAIT : IDLE;
        end
        WAIT: begin
          cnt_q <= cnt_d;
          if (cnt_d == '0) begin
            resp_data_q  <= mem_rd_data;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            cmd_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cmd_ready   = cmd_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign mem_enable  = mem_enable_q;
  assign mem_rd_wr   = mem_rd_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
`ifdef MEM_MASTER_STATS_EN
  mem_master_stats u_stats (
    .clk       (clk),
    .reset     (reset),
    .rd_inc_i  (state_q == RESP && resp_ready),
    .wr_inc_i  (state_q == ISSUE && mem_rd_wr_q == WR),
    .rd_count_o(rd_count),
    .wr_count_o(wr_count)
  );
`endif
endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: randomized bench for mem_master against a transaction-timeline model
module tb_mem_master;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int RL = 1;
  logic          clk = 0, reset = 0;
  logic          cmd_valid = 0, cmd_rd_wr = 0, resp_ready = 1;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wr_data = '0;
  logic          cmd_ready, resp_valid, mem_enable, mem_rd_wr;
  logic [DW-1:0] resp_data, mem_wr_data, mem_rd_data;
  logic [AW-1:0] mem_addr;
`ifdef MEM_MASTER_STATS_EN
  logic [15:0]   rd_count, wr_count;
`endif
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mem_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr(cmd_rd_wr),
    .cmd_addr(cmd_addr), .cmd_wr_data(cmd_wr_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .mem_enable(mem_enable), .mem_rd_wr(mem_rd_wr), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
`ifdef MEM_MASTER_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  // memory environment: reacts to the DUT pins, random garbage on idle read-data cycles
  logic [DW-1:0] env_mem [16];
  logic [DW-1:0] pipe [RL];
  assign mem_rd_data = pipe[RL-1];
  always @(posedge clk) begin
    if (mem_enable && !mem_rd_wr) env_mem[mem_addr] <= mem_wr_data;
    pipe[0] <= (mem_enable && mem_rd_wr) ? env_mem[mem_addr] : DW'($urandom);
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  // model: each command is a timeline measured in edges since its accept edge
  logic [DW-1:0] ref_mem [16];
  bit            busy = 0, rstd = 1, m_rd = 0;
  int            age = 0;
  logic [AW-1:0] m_addr = '0;
  logic          e_ready = 0, e_rv = 0, e_en = 0, e_rw = 1;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wd = '0, e_rdata = '0;
  logic [15:0]   s_wr = 0, s_rd = 0;
  initial for (int i = 0; i < 16; i++) begin env_mem[i] = '0; ref_mem[i] = '0; end
  always @(posedge clk) begin
    if (!reset) begin
      busy = 0; rstd = 1; e_rw = 1; e_addr = '0; e_wd = '0; e_rdata = '0; s_wr = 0; s_rd = 0;
    end else begin
      if (busy) begin
        if (!m_rd) begin s_wr++; busy = 0; end
        else if (e_rv && resp_ready) begin s_rd++; busy = 0; end
        age++;
      end else if (cmd_valid && e_ready) begin
        busy = 1; age = 0; m_rd = cmd_rd_wr; m_addr = cmd_addr;
        e_rw = cmd_rd_wr; e_addr = cmd_addr; e_wd = cmd_wr_data;
        if (!cmd_rd_wr) ref_mem[cmd_addr] = cmd_wr_data;
      end
      rstd = 0;
    end
    e_en = busy && age == 0;
    e_rv = busy && m_rd && age >= 1 + RL;
    if (busy && m_rd && age == 1 + RL) e_rdata = ref_mem[m_addr];
    e_ready = !rstd && !busy;
    #1;
    chk("cmd_ready", cmd_ready, e_ready);
    chk("resp_valid", resp_valid, e_rv);
    chk("resp_data", resp_data, e_rdata);
    chk("mem_enable", mem_enable, e_en);
    chk("mem_rd_wr", mem_rd_wr, e_rw);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wr_data", mem_wr_data, e_wd);
`ifdef MEM_MASTER_STATS_EN
    chk("wr_count", wr_count, s_wr);
    chk("rd_count", rd_count, s_rd);
`endif
  end
  task automatic do_cmd(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    cmd_valid = 1; cmd_rd_wr = rd; cmd_addr = a; cmd_wr_data = d; resp_ready = 1;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_bound", 32'(n < 20), 1);
    @(negedge clk);
    cmd_valid = 0;
    n = 0;
    while (rd && !resp_valid && n < 20) begin @(negedge clk); n++; end
    if (rd) begin
      chk("resp_bound", 32'(n < 20), 1);
      @(negedge clk);
    end
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_rw", mem_rd_wr, 1);
    chk("rst_en", mem_enable, 0);
    reset = 1;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);
    cmd_valid = 1; cmd_rd_wr = 0; cmd_addr = 4'h3; cmd_wr_data = 8'hA5;
    @(negedge clk);
    cmd_valid = 0; cmd_wr_data = 8'h00;
    chk("wr_en", mem_enable, 1);
    chk("wr_rw", mem_rd_wr, 0);
    chk("wr_addr", mem_addr, 4'h3);
    chk("wr_data", mem_wr_data, 8'hA5);
    chk("wr_busy", cmd_ready, 0);
    @(negedge clk);
    chk("wr_en_drop", mem_enable, 0);
    chk("wr_ready", cmd_ready, 1);
    chk("wr_noresp", resp_valid, 0);
    resp_ready = 0; cmd_valid = 1; cmd_rd_wr = 1; cmd_addr = 4'h3;
    @(negedge clk);
    cmd_valid = 0; cmd_addr = 4'h0;
    n = 1;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    chk("rd_latency", n, 2 + RL);
    chk("rd_data", resp_data, 8'hA5);
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", resp_valid, 1);
      chk("stall_data", resp_data, 8'hA5);
      chk("stall_ready", cmd_ready, 0);
    end
    resp_ready = 1;
    @(negedge clk);
    chk("hs_valid", resp_valid, 0);
    chk("hs_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_rd_wr = 1; cmd_addr = 4'h7;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("abort_valid", resp_valid, 0);
    chk("abort_en", mem_enable, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_ready", cmd_ready, 0);
    reset = 1;
    repeat (4) begin @(negedge clk); chk("abort_noresp", resp_valid, 0); end
    do_cmd(0, 4'h1, 8'h11);
    do_cmd(0, 4'h2, 8'h22);
    do_cmd(0, 4'h7, 8'h5C);
    do_cmd(1, 4'h7, 8'h00);
    chk("rd7_data", resp_data, 8'h5C);
    do_cmd(1, 4'h3, 8'h00);
    chk("rd3_data", resp_data, 8'hA5);
`ifdef MEM_MASTER_STATS_EN
    chk("wr_count3", wr_count, 3);
    chk("rd_count2", rd_count, 2);
    force dut.u_stats.wr_q = 16'hFFFF;
    s_wr = 16'hFFFF;
    @(negedge clk);
    release dut.u_stats.wr_q;
    do_cmd(0, 4'h9, 8'h99);
    chk("wr_wrap", wr_count, 0);
`endif
    repeat (3000) begin
      @(negedge clk);
      reset       = ($urandom % 150) != 0;
      cmd_valid   = $urandom_range(0, 1) == 1;
      cmd_rd_wr   = $urandom_range(0, 1) == 1;
      cmd_addr    = AW'($urandom);
      cmd_wr_data = DW'($urandom);
      resp_ready  = ($urandom % 4) != 0;
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_master.md
Name: mem_master

Overview:
- Initiator for the memory port used by the `mem` block.
- Accepts single read/write commands from an upstream client (ALU/sequencer side) on a valid/ready handshake.
- Drives the memory port for exactly one cycle per command.
- For reads, captures the returned data after a fixed latency and presents it on a valid/ready response channel.

Parameters:
- DATA_WIDTH, 8, width of memory data word and command write data.
- ADDR_WIDTH, 4, width of memory address; memory depth is 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from the issue edge to the edge on which mem_rd_data is sampled; legal range 1..4.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-low (reset==0 resets on the posedge of clk).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_rd_wr  in  1  1=read, 0=write (same encoding as the memory port).
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wr_data  in  DATA_WIDTH  write data; ignored for reads.
- resp_valid  out  1  read data available.
- resp_ready  in  1  consumer accepts read data.
- resp_data  out  DATA_WIDTH  read data.
- mem_enable  out  1  memory access strobe.
- mem_rd_wr  out  1  memory access direction.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wr_data  out  DATA_WIDTH  memory write data.
- mem_rd_data  in  DATA_WIDTH  memory read data.

Behaviour:
- Reset values:
  - cmd_ready=0, resp_valid=0, resp_data=0.
  - mem_enable=0, mem_rd_wr=1, mem_addr=0, mem_wr_data=0.
  - FSM=IDLE, latency counter=0.
  - cmd_ready rises in the first cycle after reset is released.
- FSM states and transitions:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch rd_wr, addr and wr_data into registers, then go to ISSUE.
  - ISSUE: mem_enable=1 for exactly one cycle, with mem_rd_wr/mem_addr/mem_wr_data driven from the latched registers.
    - Write: next state IDLE. Writes produce no response.
    - Read: load counter=READ_LATENCY, next state WAIT.
  - WAIT: mem_enable=0 and counter decrements each cycle. On the edge where the counter reaches 0, register mem_rd_data into resp_data and go to RESP.
  - RESP: resp_valid=1; resp_data is stable until resp_ready. On resp_valid&&resp_ready, next state IDLE and resp_valid drops the following cycle.
- Port signals outside ISSUE: mem_addr, mem_rd_wr and mem_wr_data hold their last values; mem_enable=0.
- Command throughput: one command in flight at a time; cmd_ready=0 outside IDLE.
  - Write: accept-to-accept minimum of 2 cycles.
  - Read: minimum of 3+READ_LATENCY cycles with resp_ready tied high.
- Read latency, command accept edge to resp_valid high: 2+READ_LATENCY cycles.
- Command signals are sampled only on the accept edge; changes afterwards are ignored.
- resp_ready low stalls indefinitely in RESP; no new command is accepted during the stall.
- Reset asserted mid-operation in any state: the command is abandoned with no response, and all outputs take their reset values on that edge.
- Addresses are not range-checked: every ADDR_WIDTH value is valid and there is no wrap logic.
- cmd_valid asserted during reset is ignored.

Optional Feature:
- MEM_MASTER_STATS_EN defined adds two outputs:
  - rd_count [15:0]: increments on each read response handshake.
  - wr_count [15:0]: increments on each write ISSUE cycle.
  - Both counters wrap 0xFFFF->0 and reset to 0.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package mem_pkg holds:
  - the FSM state typedef (IDLE, ISSUE, WAIT, RESP);
  - constants RD=1'b1 and WR=1'b0;
  - default DATA_WIDTH/ADDR_WIDTH values.
- No sub-module is needed. The optional counters are a natural small sub-module, mem_master_stats.

Test Plan:
- Reset low for 3 cycles, then high: all outputs at reset values during reset; cmd_ready=1 one cycle after release.
- Write addr 0x3 data 0xA5: mem_enable=1 for one cycle with mem_rd_wr=0, mem_addr=0x3, mem_wr_data=0xA5; cmd_ready back high 2 cycles after accept; resp_valid never asserts.
- Write 0x3=0xA5 then read 0x3, against a memory model with READ_LATENCY=1: resp_valid high 3 cycles after read accept with resp_data=0xA5.
- Read with resp_ready held low for 5 cycles: resp_valid and resp_data stay stable and cmd_ready=0 throughout; handshake on release, then cmd_ready=1 the next cycle.
- Reset pulsed during WAIT of a read to 0x7: no response appears; mem_enable=0; next command completes normally.
- With MEM_MASTER_STATS_EN defined: 3 writes + 2 reads -> wr_count=3, rd_count=2. Counter preset via force to 0xFFFF, then one write -> wr_count=0.
